// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Sums BURST consecutive 5-bit adder results ({carry,sum0,sum1,sum2,sum3})
//   into a 7-bit total and presents the total to a downstream consumer.
//
//   Parameter:
//     BURST      number of samples summed per burst (legal range 1..8)
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     clear      synchronous abort, returns to IDLE and zeroes all state
//     in_valid   upstream sample present
//     sum0..sum3 adder sum bits, sum0 is the MSB (weight 8), sum3 the LSB
//     carry      adder carry out (weight 16)
//     in_ready   block accepts a sample this cycle
//     out_ready  downstream accepts the burst total
//     out_valid  acc holds a completed burst total
//     acc        running / final total
//     count      samples accepted in the current burst minus one (mod 8)
//     overflow   sticky: true total exceeded 127 during the current burst
//     fsm_state  current FSM state (debug visibility)
//
//   Handshake: a sample transfers on a rising clk edge iff in_valid and
//   in_ready are both 1; the burst total transfers on a rising edge iff
//   out_valid and out_ready are both 1. in_ready depends only on state, never
//   on in_valid, so there is no combinational path from the inputs to it.
//
//   Build option: define ACC_SATURATE_EN to clamp acc at 127 on overflow;
//   otherwise acc wraps modulo 128. overflow is set in both builds.

module sum_accumulator #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic       sum0,
  input  logic       sum1,
  input  logic       sum2,
  input  logic       sum3,
  input  logic       carry,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [6:0] acc,
  output logic [2:0] count,
  output logic       overflow,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // count value held once the burst's last sample has been taken
  localparam logic [2:0] LAST_CNT = 3'(BURST - 1);

  state_t     state, state_nxt;
  logic [6:0] acc_nxt;
  logic [2:0] count_nxt;
  logic       overflow_nxt;
  logic [4:0] sample;
  logic [7:0] sum8;
  logic       accept;

  assign sample    = {carry, sum0, sum1, sum2, sum3};
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign fsm_state = state;

  // one extra bit so the true total is visible for overflow detection
  assign sum8 = {1'b0, acc} + {3'b000, sample};

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    count_nxt    = count;
    overflow_nxt = overflow;
    if (clear) begin
      state_nxt    = IDLE;
      acc_nxt      = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt      = {2'b00, sample};
            count_nxt    = '0;
            overflow_nxt = 1'b0;
            state_nxt    = (BURST == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            count_nxt    = count + 3'd1;
            overflow_nxt = overflow | sum8[7];
`ifdef ACC_SATURATE_EN
            // once clamped, later adds also exceed 127 so acc stays at 127
            acc_nxt      = sum8[7] ? 7'd127 : sum8[6:0];
`else
            acc_nxt      = sum8[6:0];
`endif
            if (count_nxt == LAST_CNT) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          // results stay visible in IDLE until the next burst starts
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      count    <= count_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator
//   Three instances (BURST = 4, 8, 1) share every input; each scenario starts
//   from a clear so the instance under observation has a known state.
//   Inputs change on the falling edge; outputs are observed on the falling
//   edge, half a cycle after the active edge.

module tb_sum_accumulator;

  logic clk;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic sum0, sum1, sum2, sum3, carry;
  logic out_ready;

  logic       in_ready_4, out_valid_4, overflow_4;
  logic [6:0] acc_4;
  logic [2:0] count_4;
  logic [1:0] st_4;
  logic       in_ready_8, out_valid_8, overflow_8;
  logic [6:0] acc_8;
  logic [2:0] count_8;
  logic [1:0] st_8;
  logic       in_ready_1, out_valid_1, overflow_1;
  logic [6:0] acc_1;
  logic [2:0] count_1;
  logic [1:0] st_1;

  int n_checks;
  int n_fail;

  // observation mux: 0 -> BURST 4, 1 -> BURST 8, 2 -> BURST 1
  int         sel;
  logic       obs_in_ready, obs_out_valid, obs_overflow;
  logic [6:0] obs_acc;
  logic [2:0] obs_count;

  logic [4:0] exp_q[$];

  sum_accumulator #(.BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3), .carry(carry),
    .in_ready(in_ready_4), .out_ready(out_ready), .out_valid(out_valid_4),
    .acc(acc_4), .count(count_4), .overflow(overflow_4), .fsm_state(st_4)
  );

  sum_accumulator #(.BURST(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3), .carry(carry),
    .in_ready(in_ready_8), .out_ready(out_ready), .out_valid(out_valid_8),
    .acc(acc_8), .count(count_8), .overflow(overflow_8), .fsm_state(st_8)
  );

  sum_accumulator #(.BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .sum0(sum0), .sum1(sum1), .sum2(sum2), .sum3(sum3), .carry(carry),
    .in_ready(in_ready_1), .out_ready(out_ready), .out_valid(out_valid_1),
    .acc(acc_1), .count(count_1), .overflow(overflow_1), .fsm_state(st_1)
  );

  always_comb begin
    obs_in_ready  = in_ready_4;
    obs_out_valid = out_valid_4;
    obs_overflow  = overflow_4;
    obs_acc       = acc_4;
    obs_count     = count_4;
    if (sel == 1) begin
      obs_in_ready  = in_ready_8;
      obs_out_valid = out_valid_8;
      obs_overflow  = overflow_8;
      obs_acc       = acc_8;
      obs_count     = count_8;
    end else if (sel == 2) begin
      obs_in_ready  = in_ready_1;
      obs_out_valid = out_valid_1;
      obs_overflow  = overflow_1;
      obs_acc       = acc_1;
      obs_count     = count_1;
    end
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Samples are non-negative, so "some partial total exceeded 127" is the
  // same as "the final true total exceeds 127".
  function automatic int model_acc(input int total);
`ifdef ACC_SATURATE_EN
    return (total > 127) ? 127 : total;
`else
    return total % 128;
`endif
  endfunction

  function automatic int model_ovf(input int total);
    return (total > 127) ? 1 : 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_sample(input logic [4:0] v);
    {carry, sum0, sum1, sum2, sum3} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      n_checks++;
      if (obs_acc !== 7'd0 || obs_count !== 3'd0 || obs_overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_regs dut%0d: acc=%0d count=%0d ovf=%0b, required 0/0/0",
                 i, obs_acc, obs_count, obs_overflow);
      end
      n_checks++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hs dut%0d: out_valid=%0b in_ready=%0b, required 0/1",
                 i, obs_out_valid, obs_in_ready);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_burst();
    logic [4:0] samples [4];
    int running;
    samples = '{5'd3, 5'd5, 5'd7, 5'd9};
    sel = 0;
    do_clear();
    running = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_sample(samples[i]);
      tick();
      running += samples[i];
      n_checks++;
      if (int'(obs_acc) !== running || int'(obs_count) !== i) begin
        n_fail++;
        $display("FAIL basic_running[%0d]: acc=%0d count=%0d, required %0d/%0d",
                 i, obs_acc, obs_count, running, i);
      end
      // out_valid appears exactly 4 cycles after the first accept
      n_checks++;
      if (obs_out_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: out_valid=%0b required %0b",
                 i, obs_out_valid, (i == 3));
      end
    end
    n_checks++;
    if (obs_acc !== 7'd24 || obs_count !== 3'd3 || obs_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_total: acc=%0d count=%0d ovf=%0b, required 24/3/0",
               obs_acc, obs_count, obs_overflow);
    end
  endtask

  // continues from the DONE state left by test_basic_burst
  task automatic test_done_hold();
    sel = 0;
    in_valid = 1'b1;
    drive_sample(5'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs_acc !== 7'd24 || obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL done_hold[%0d]: acc=%0d in_ready=%0b out_valid=%0b, required 24/0/1",
                 i, obs_acc, obs_in_ready, obs_out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_acc !== 7'd24 ||
        obs_count !== 3'd3) begin
      n_fail++;
      $display("FAIL done_release: out_valid=%0b in_ready=%0b acc=%0d count=%0d, required 0/1/24/3",
               obs_out_valid, obs_in_ready, obs_acc, obs_count);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs_acc !== 7'd2 || obs_count !== 3'd0 || obs_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_next_accept: acc=%0d count=%0d out_valid=%0b, required 2/0/0",
               obs_acc, obs_count, obs_out_valid);
    end
  endtask

  task automatic test_max_burst();
    int total;
    sel = 1;
    do_clear();
    in_valid = 1'b1;
    drive_sample(5'd31);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total += 31;
      n_checks++;
      if (int'(obs_acc) !== model_acc(total) || int'(obs_overflow) !== model_ovf(total)) begin
        n_fail++;
        $display("FAIL max_burst[%0d]: acc=%0d ovf=%0b, required %0d/%0d",
                 i, obs_acc, obs_overflow, model_acc(total), model_ovf(total));
      end
    end
    in_valid = 1'b0;
    n_checks++;
`ifdef ACC_SATURATE_EN
    if (obs_out_valid !== 1'b1 || obs_acc !== 7'd127 || obs_overflow !== 1'b1 ||
        obs_count !== 3'd7) begin
      n_fail++;
      $display("FAIL max_total: out_valid=%0b acc=%0d ovf=%0b count=%0d, required 1/127/1/7",
               obs_out_valid, obs_acc, obs_overflow, obs_count);
    end
`else
    if (obs_out_valid !== 1'b1 || obs_acc !== 7'd120 || obs_overflow !== 1'b1 ||
        obs_count !== 3'd7) begin
      n_fail++;
      $display("FAIL max_total: out_valid=%0b acc=%0d ovf=%0b count=%0d, required 1/120/1/7",
               obs_out_valid, obs_acc, obs_overflow, obs_count);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    sel = 0;
    do_clear();
    in_valid = 1'b1;
    drive_sample(5'd4);
    tick();
    drive_sample(5'd6);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs_acc !== 7'd10) begin
      n_fail++;
      $display("FAIL midrst_partial: acc=%0d required 10", obs_acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_acc !== 7'd0 || obs_count !== 3'd0 || obs_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: acc=%0d count=%0d in_ready=%0b, required 0/0/1",
               obs_acc, obs_count, obs_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    drive_sample(5'd1);
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs_out_valid !== 1'b1 || obs_acc !== 7'd4 || obs_count !== 3'd3) begin
      n_fail++;
      $display("FAIL midrst_new_burst: out_valid=%0b acc=%0d count=%0d, required 1/4/3",
               obs_out_valid, obs_acc, obs_count);
    end
  endtask

  task automatic test_clear();
    sel = 0;
    do_clear();
    in_valid = 1'b1;
    drive_sample(5'd5);
    tick();
    drive_sample(5'd6);
    tick();
    drive_sample(5'd7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (obs_acc !== 7'd0 || obs_count !== 3'd0 || obs_overflow !== 1'b0 ||
        obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_drop: acc=%0d count=%0d ovf=%0b out_valid=%0b in_ready=%0b, required 0/0/0/0/1",
               obs_acc, obs_count, obs_overflow, obs_out_valid, obs_in_ready);
    end
    sel = 2;
    in_valid = 1'b1;
    drive_sample(5'd17);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs_out_valid !== 1'b1 || obs_acc !== 7'd17 || obs_count !== 3'd0) begin
      n_fail++;
      $display("FAIL burst1: out_valid=%0b acc=%0d count=%0d, required 1/17/0",
               obs_out_valid, obs_acc, obs_count);
    end
  endtask

  task automatic test_random(input int which, input int nbursts);
    int burst;
    int total;
    int cycles;
    int hold;
    logic [4:0] s;
    logic took;
    sel = which;
    burst = (which == 0) ? 4 : (which == 1) ? 8 : 1;
    do_clear();
    for (int b = 0; b < nbursts; b++) begin
      exp_q.delete();
      cycles = 0;
      // collection phase: the model says the block is ready throughout
      while (exp_q.size() < burst && cycles < 200) begin
        took = ($urandom_range(0, 3) != 0);
        s = 5'($urandom_range(0, 31));
        in_valid = took;
        drive_sample(s);
        tick();
        cycles++;
        if (took) exp_q.push_back(s);
        if (exp_q.size() < burst) begin
          n_checks++;
          if (obs_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_early_valid dut%0d burst %0d: out_valid=%0b required 0",
                     which, b, obs_out_valid);
          end
        end
      end
      if (cycles >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_timeout dut%0d burst %0d: cycles=%0d limit 200", which, b, cycles);
      end
      total = 0;
      foreach (exp_q[k]) total += int'(exp_q[k]);
      n_checks++;
      if (obs_out_valid !== 1'b1 || int'(obs_acc) !== model_acc(total) ||
          int'(obs_overflow) !== model_ovf(total) || int'(obs_count) !== (burst - 1)) begin
        n_fail++;
        $display("FAIL rnd_total dut%0d burst %0d: out_valid=%0b acc=%0d ovf=%0b count=%0d, required 1/%0d/%0d/%0d",
                 which, b, obs_out_valid, obs_acc, obs_overflow, obs_count,
                 model_acc(total), model_ovf(total), burst - 1);
      end
      // downstream stall with random upstream traffic that must be refused
      hold = $urandom_range(0, 3);
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        in_valid = $urandom_range(0, 1);
        drive_sample(5'($urandom_range(0, 31)));
        tick();
        n_checks++;
        if (obs_out_valid !== 1'b1 || int'(obs_acc) !== model_acc(total)) begin
          n_fail++;
          $display("FAIL rnd_hold dut%0d burst %0d: out_valid=%0b acc=%0d, required 1/%0d",
                   which, b, obs_out_valid, obs_acc, model_acc(total));
        end
      end
      out_ready = 1'b1;
      in_valid = $urandom_range(0, 1);
      drive_sample(5'($urandom_range(0, 31)));
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (obs_out_valid !== 1'b0 || int'(obs_acc) !== model_acc(total)) begin
        n_fail++;
        $display("FAIL rnd_release dut%0d burst %0d: out_valid=%0b acc=%0d, required 0/%0d",
                 which, b, obs_out_valid, obs_acc, model_acc(total));
      end
    end
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    sel = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_sample(5'd0);

    test_reset();
    test_basic_burst();
    test_done_hold();
    test_max_burst();
    test_reset_mid_burst();
    test_clear();
    test_random(0, 6);
    test_random(1, 5);
    test_random(2, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter BURST, default 4, meaning number of adder results summed per burst; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 clear  input  1  synchronous abort; return to IDLE, zero all state.
REQ-005 in_valid  input  1  upstream 4-bit full adder result present this cycle.
REQ-006 sum0  input  1  adder sum bit, MSB (weight 8).
REQ-007 sum1  input  1  adder sum bit, weight 4.
REQ-008 sum2  input  1  adder sum bit, weight 2.
REQ-009 sum3  input  1  adder sum bit, LSB (weight 1).
REQ-010 carry  input  1  adder carry out, weight 16.
REQ-011 in_ready  output  1  block accepts a sample this cycle.
REQ-012 out_ready  input  1  downstream accepts the burst total.
REQ-013 out_valid  output  1  acc holds a completed burst total.
REQ-014 acc  output  7  running/final total.
REQ-015 count  output  3  samples accepted in the current burst minus one, modulo 8.
REQ-016 overflow  output  1  sticky flag: total exceeded 127 during the current burst.

Function
REQ-017 The sample value SHALL be the 5-bit unsigned {carry,sum0,sum1,sum2,sum3}, range 0..31, zero-extended to 7 bits.
REQ-018 A sample SHALL be accepted on a rising clk edge iff in_valid=1 and in_ready=1.
REQ-019 States SHALL be IDLE, ACCUM and DONE; in_ready=1 in IDLE and ACCUM, 0 in DONE; out_valid=1 only in DONE.
REQ-020 IDLE + accept: acc<=sample, count<=0, overflow<=0; next state ACCUM, or DONE if BURST=1.
REQ-021 ACCUM + accept: acc<=acc+sample (7-bit), count<=count+1; overflow<=1 if the 8-bit true sum exceeds 127.
REQ-022 The accept that brings the accepted total to BURST SHALL move ACCUM to DONE on the same edge; out_valid asserts the following cycle.
REQ-023 ACCUM without accept SHALL hold all registers (gaps in in_valid permitted, unbounded).
REQ-024 DONE SHALL hold acc, count, overflow stable until out_ready=1, then go to IDLE on that edge; acc, count, overflow keep their values in IDLE until the next accept.
REQ-025 DONE with in_valid=1 and out_ready=1 in the same cycle SHALL NOT accept the sample (in_ready=0); it is accepted no earlier than the next cycle, in IDLE.
REQ-026 clear=1 SHALL override every other input: next state IDLE, acc=0, count=0, overflow=0, regardless of in_valid/out_ready.
REQ-027 Latency: first-accept to out_valid SHALL be exactly BURST cycles when in_valid is held high.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, acc=0, count=0, overflow=0, out_valid=0, in_ready=1.
REQ-029 Reset asserted mid-burst SHALL discard the partial total; the first accept after release starts a new burst.
REQ-030 Deassertion of rst_n SHALL be taken synchronously to clk; no accept occurs on the releasing edge.

Configuration
REQ-031 Macro ACC_SATURATE_EN: when defined, an ACCUM add exceeding 127 SHALL set acc=127 (held at 127 for the rest of the burst) and set overflow.
REQ-032 Without ACC_SATURATE_EN, acc SHALL wrap modulo 128 and overflow still sets; all other behaviour identical.

Verification
REQ-033 BURST=4, in_valid held high, samples 3,5,7,9 -> out_valid after 4th accept, acc=24, count=3, overflow=0.
REQ-034 BURST=8, eight samples of 31 (carry=1, all sums=1) -> true total 248; without macro acc=120, with macro acc=127; overflow=1 in both cases.
REQ-035 DONE with out_ready=0 for 5 cycles while in_valid=1 -> acc stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle; sample accepted the cycle after.
REQ-036 BURST=4, rst_n pulsed low after 2 accepts (total 10) -> acc=0 immediately; new burst 1,1,1,1 -> acc=4.
REQ-037 clear=1 in same cycle as 3rd accept -> sample dropped, acc=0, state IDLE; BURST=1 with sample 17 -> out_valid next cycle, acc=17.
